// File: rtl/core_wm_pkg.sv
// Shared widths and FSM state encoding for the conv-core line write master.
package core_wm_pkg;

    localparam int LINE_W   = 1024;
    localparam int BE_W     = 128;
    localparam int ADDR_W   = 64;
    localparam int HEIGHT_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/core_wm_fifo.sv
// Show-ahead synchronous FIFO holding {line, first, last} between the output
// buffer and the Avalon write port.
module core_wm_fifo
    import core_wm_pkg::*;
#(
    parameter int FifoDepth = 4,
    parameter int W         = LINE_W + 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(FifoDepth);

    logic [W-1:0] r_mem [FifoDepth];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full)
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (i_pop && !o_empty)
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !o_full)
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/core_write_master.sv
// Avalon-MM write master storing result lines at consecutive addresses from
// InitialAddr. Define CORE_WRITE_MASTER_LOCK_EN to hold AvalonLock_o across RUN.
module core_write_master
    import core_wm_pkg::*;
#(
    parameter logic [ADDR_W-1:0] InitialAddr = 64'h0,
    parameter int                FifoDepth   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Start_i,
    input  logic [HEIGHT_W-1:0] Height_i,
    input  logic                Valid_i,
    input  logic [LINE_W-1:0]   Line_i,
    input  logic                First_i,
    input  logic                Last_i,
    output logic                Halt_o,
    output logic [ADDR_W-1:0]   AvalonAddr_o,
    output logic                AvalonWrite_o,
    output logic                AvalonRead_o,
    output logic [BE_W-1:0]     AvalonByteEnable_o,
    output logic [LINE_W-1:0]   AvalonWriteData_o,
    input  logic [LINE_W-1:0]   AvalonReadData_i,
    output logic                AvalonLock_o,
    input  logic                AvalonWaitReq_i,
    output logic                Done_o,
    output logic                Err_o
);

    state_t              r_state, w_state_nxt;
    logic [HEIGHT_W-1:0] r_height;
    logic [HEIGHT_W-1:0] r_push_cnt;
    logic [HEIGHT_W-1:0] r_wr_cnt;
    logic                r_err;

    logic                w_full, w_empty, w_halt;
    logic [LINE_W+1:0]   w_head;
    logic                w_start, w_push_try, w_all_pushed, w_push, w_pop, w_write;
    logic                w_last_idx, w_frame_err, w_err_set;
    logic                w_unused;

    assign w_start      = Start_i && (r_state == ST_IDLE);
    assign w_halt       = w_full || (r_state != ST_RUN);
    assign w_push_try   = Valid_i && !w_halt;
    assign w_all_pushed = (r_push_cnt == r_height);
    assign w_push       = w_push_try && !w_all_pushed;
    assign w_write      = !w_empty && (r_state == ST_RUN);
    assign w_pop        = w_write && !AvalonWaitReq_i;

    // Framing is judged on the push index, independent of slave progress.
    assign w_last_idx  = (r_push_cnt == r_height - HEIGHT_W'(1));
    assign w_frame_err = w_push && ((First_i && (r_push_cnt != '0)) ||
                                    (Last_i != w_last_idx));
    assign w_err_set   = (Valid_i && w_halt) || (w_push_try && w_all_pushed) ||
                         w_frame_err;

    core_wm_fifo #(
        .FifoDepth (FifoDepth),
        .W         (LINE_W + 2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_start),
        .i_push  (w_push),
        .i_data  ({Line_i, First_i, Last_i}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (Start_i) w_state_nxt = (Height_i == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (w_pop && (r_wr_cnt == r_height - HEIGHT_W'(1)))
                         w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_height   <= '0;
            r_push_cnt <= '0;
            r_wr_cnt   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_height   <= Height_i;
                r_push_cnt <= '0;
                r_wr_cnt   <= '0;
                r_err      <= 1'b0;
            end else begin
                if (w_push)    r_push_cnt <= r_push_cnt + HEIGHT_W'(1);
                if (w_pop)     r_wr_cnt   <= r_wr_cnt + HEIGHT_W'(1);
                if (w_err_set) r_err      <= 1'b1;
            end
        end
    end

    // Bus fields are zeroed between writes so idle/reset shows a quiet bus.
    assign AvalonWrite_o      = w_write;
    assign AvalonAddr_o       = w_write ? InitialAddr + {{(ADDR_W-HEIGHT_W){1'b0}}, r_wr_cnt} : '0;
    assign AvalonWriteData_o  = w_write ? w_head[LINE_W+1:2] : '0;
    assign AvalonRead_o       = 1'b0;
    assign AvalonByteEnable_o = '1;
    assign Halt_o             = w_halt;
    assign Done_o             = (r_state == ST_DONE);
    assign Err_o              = r_err;

`ifdef CORE_WRITE_MASTER_LOCK_EN
    assign AvalonLock_o = (r_state == ST_RUN);
`else
    assign AvalonLock_o = 1'b0;
`endif

    assign w_unused = ^{AvalonReadData_i, w_head[1:0]};

endmodule

// File: tb/tb_core_write_master.sv
// Directed per-cycle vector table for core_write_master plus a randomized
// waitrequest frame checked against a simple address/data scoreboard.
module tb_core_write_master;
    import core_wm_pkg::*;

    localparam logic [63:0] BASE = 64'h100;

    logic                clk = 1'b0;
    logic                rst;
    logic                Start_i;
    logic [HEIGHT_W-1:0] Height_i;
    logic                Valid_i;
    logic [LINE_W-1:0]   Line_i;
    logic                First_i;
    logic                Last_i;
    logic                Halt_o;
    logic [ADDR_W-1:0]   AvalonAddr_o;
    logic                AvalonWrite_o;
    logic                AvalonRead_o;
    logic [BE_W-1:0]     AvalonByteEnable_o;
    logic [LINE_W-1:0]   AvalonWriteData_o;
    logic [LINE_W-1:0]   AvalonReadData_i;
    logic                AvalonLock_o;
    logic                AvalonWaitReq_i;
    logic                Done_o;
    logic                Err_o;

    core_write_master #(.InitialAddr(BASE), .FifoDepth(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .Start_i            (Start_i),
        .Height_i           (Height_i),
        .Valid_i            (Valid_i),
        .Line_i             (Line_i),
        .First_i            (First_i),
        .Last_i             (Last_i),
        .Halt_o             (Halt_o),
        .AvalonAddr_o       (AvalonAddr_o),
        .AvalonWrite_o      (AvalonWrite_o),
        .AvalonRead_o       (AvalonRead_o),
        .AvalonByteEnable_o (AvalonByteEnable_o),
        .AvalonWriteData_o  (AvalonWriteData_o),
        .AvalonReadData_i   (AvalonReadData_i),
        .AvalonLock_o       (AvalonLock_o),
        .AvalonWaitReq_i    (AvalonWaitReq_i),
        .Done_o             (Done_o),
        .Err_o              (Err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst, st;
        logic [8:0]  h;
        logic        vl, fi, la, wq;
        logic [31:0] tag;
        logic        e_wr;
        logic [63:0] e_addr;
        logic [31:0] e_tag;
        logic        e_halt, e_done, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int r, st, h, vl, fi, la, wq, tag,
                                input int ewr, eaddr, etag, ehalt, edone, eerr);
        vec_t v;
        v.rst = 1'(r);  v.st = 1'(st);  v.h = 9'(h);
        v.vl = 1'(vl);  v.fi = 1'(fi);  v.la = 1'(la);  v.wq = 1'(wq);
        v.tag = 32'(tag);
        v.e_wr = 1'(ewr);  v.e_addr = 64'(eaddr);  v.e_tag = 32'(etag);
        v.e_halt = 1'(ehalt);  v.e_done = 1'(edone);  v.e_err = 1'(eerr);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [31:0] tag, input logic wr);
        logic [LINE_W-1:0] exp;
        exp = wr ? {32{tag}} : '0;
        checks++;
        if (AvalonWriteData_o !== exp) begin
            errors++;
            $display("FAIL %s: got low word %0h expected %0h", name,
                     AvalonWriteData_o[31:0], exp[31:0]);
        end
    endtask

    initial begin
        int pushed, acc;
        logic done_seen;

        rst = 1'b1; Start_i = 0; Height_i = '0; Valid_i = 0; Line_i = '0;
        First_i = 0; Last_i = 0; AvalonReadData_i = '0; AvalonWaitReq_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset write", AvalonWrite_o, 0);
        chk("reset addr", AvalonAddr_o, 0);
        chk_data("reset data", 0, 1'b0);
        chk("reset halt", Halt_o, 1);
        chk("reset done", Done_o, 0);
        chk("reset err", Err_o, 0);
        chk("reset lock", AvalonLock_o, 0);
        chk("reset read", AvalonRead_o, 0);
        chk("reset byteenable", {63'd0, &AvalonByteEnable_o}, 1);
        rst = 1'b0;

        // Basic frame, Height=4
        add(0,1,4,0,0,0,0,0,      0,0,0,        1,0,0);
        add(0,0,0,1,1,0,0,'hA0,   0,0,0,        0,0,0);
        add(0,0,0,1,0,0,0,'hA1,   1,'h100,'hA0, 0,0,0);
        add(0,0,0,1,0,0,0,'hA2,   1,'h101,'hA1, 0,0,0);
        add(0,0,0,1,0,1,0,'hA3,   1,'h102,'hA2, 0,0,0);
        add(0,0,0,0,0,0,0,0,      1,'h103,'hA3, 0,0,0);
        add(0,0,0,0,0,0,0,0,      0,0,0,        1,1,0);
        add(0,0,0,0,0,0,0,0,      0,0,0,        1,0,0);
        // Zero height
        add(0,1,0,0,0,0,0,0,      0,0,0,        1,0,0);
        add(0,0,0,0,0,0,0,0,      0,0,0,        1,1,0);
        add(0,0,0,0,0,0,0,0,      0,0,0,        1,0,0);
        // Slave stall, Height=8, waitrequest high 6 cycles
        add(0,1,8,0,0,0,0,0,      0,0,0,        1,0,0);
        add(0,0,0,1,1,0,0,'hB0,   0,0,0,        0,0,0);
        add(0,0,0,1,0,0,1,'hB1,   1,'h100,'hB0, 0,0,0);
        add(0,0,0,1,0,0,1,'hB2,   1,'h100,'hB0, 0,0,0);
        add(0,0,0,1,0,0,1,'hB3,   1,'h100,'hB0, 0,0,0);
        add(0,0,0,0,0,0,1,0,      1,'h100,'hB0, 1,0,0);
        add(0,0,0,0,0,0,1,0,      1,'h100,'hB0, 1,0,0);
        add(0,0,0,0,0,0,1,0,      1,'h100,'hB0, 1,0,0);
        add(0,0,0,0,0,0,0,0,      1,'h100,'hB0, 1,0,0);
        add(0,0,0,1,0,0,0,'hB4,   1,'h101,'hB1, 0,0,0);
        add(0,0,0,1,0,0,0,'hB5,   1,'h102,'hB2, 0,0,0);
        add(0,0,0,1,0,0,0,'hB6,   1,'h103,'hB3, 0,0,0);
        add(0,0,0,1,0,1,0,'hB7,   1,'h104,'hB4, 0,0,0);
        add(0,0,0,0,0,0,0,0,      1,'h105,'hB5, 0,0,0);
        add(0,0,0,0,0,0,0,0,      1,'h106,'hB6, 0,0,0);
        add(0,0,0,0,0,0,0,0,      1,'h107,'hB7, 0,0,0);
        add(0,0,0,0,0,0,0,0,      0,0,0,        1,1,0);
        add(0,0,0,0,0,0,0,0,      0,0,0,        1,0,0);
        // Framing error: Height=3, Last on 2nd line; sticky until next Start
        add(0,1,3,0,0,0,0,0,      0,0,0,        1,0,0);
        add(0,0,0,1,1,0,0,'hC0,   0,0,0,        0,0,0);
        add(0,0,0,1,0,1,0,'hC1,   1,'h100,'hC0, 0,0,0);
        add(0,0,0,1,0,0,0,'hC2,   1,'h101,'hC1, 0,0,1);
        add(0,0,0,0,0,0,0,0,      1,'h102,'hC2, 0,0,1);
        add(0,0,0,0,0,0,0,0,      0,0,0,        1,1,1);
        add(0,0,0,0,0,0,0,0,      0,0,0,        1,0,1);
        add(0,1,0,0,0,0,0,0,      0,0,0,        1,0,1);
        add(0,0,0,0,0,0,0,0,      0,0,0,        1,1,0);
        add(0,0,0,0,0,0,0,0,      0,0,0,        1,0,0);
        // Overflow while halted, then reset mid-frame and a clean frame
        add(0,1,5,0,0,0,0,0,      0,0,0,        1,0,0);
        add(0,0,0,1,1,0,1,'hD0,   0,0,0,        0,0,0);
        add(0,0,0,1,0,0,1,'hD1,   1,'h100,'hD0, 0,0,0);
        add(0,0,0,1,0,0,1,'hD2,   1,'h100,'hD0, 0,0,0);
        add(0,0,0,1,0,0,1,'hD3,   1,'h100,'hD0, 0,0,0);
        add(0,0,0,1,0,0,1,'hD4,   1,'h100,'hD0, 1,0,0);
        add(0,0,0,0,0,0,1,0,      1,'h100,'hD0, 1,0,1);
        add(1,0,0,0,0,0,1,0,      1,'h100,'hD0, 1,0,1);
        add(0,1,2,0,0,0,0,0,      0,0,0,        1,0,0);
        add(0,0,0,1,1,0,0,'hE0,   0,0,0,        0,0,0);
        add(0,0,0,1,0,1,0,'hE1,   1,'h100,'hE0, 0,0,0);
        add(0,0,0,0,0,0,0,0,      1,'h101,'hE1, 0,0,0);
        add(0,0,0,0,0,0,0,0,      0,0,0,        1,1,0);
        add(0,0,0,0,0,0,0,0,      0,0,0,        1,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst             = vecs[i].rst;
            Start_i         = vecs[i].st;
            Height_i        = vecs[i].h;
            Valid_i         = vecs[i].vl;
            First_i         = vecs[i].fi;
            Last_i          = vecs[i].la;
            AvalonWaitReq_i = vecs[i].wq;
            Line_i          = vecs[i].vl ? {32{vecs[i].tag}} : '0;
            #1;
            chk($sformatf("row%0d write", i), AvalonWrite_o, vecs[i].e_wr);
            chk($sformatf("row%0d addr", i), AvalonAddr_o, vecs[i].e_addr);
            chk_data($sformatf("row%0d data", i), vecs[i].e_tag, vecs[i].e_wr);
            chk($sformatf("row%0d halt", i), Halt_o, vecs[i].e_halt);
            chk($sformatf("row%0d done", i), Done_o, vecs[i].e_done);
            chk($sformatf("row%0d err", i), Err_o, vecs[i].e_err);
        end

        // Random waitrequest frame, Height=3
        @(negedge clk);
        rst = 0; Start_i = 1; Height_i = 9'd3; Valid_i = 0; First_i = 0; Last_i = 0;
        AvalonWaitReq_i = 0;
        pushed = 0; acc = 0; done_seen = 1'b0;
        for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
            @(negedge clk);
            Start_i = 0;
            AvalonWaitReq_i = 1'($urandom_range(0, 1));
            if (!Halt_o && pushed < 3) begin
                Valid_i = 1; First_i = (pushed == 0); Last_i = (pushed == 2);
                Line_i  = {32{32'hF0 + 32'(pushed)}};
                pushed++;
            end else begin
                Valid_i = 0; First_i = 0; Last_i = 0; Line_i = '0;
            end
            #1;
            if (AvalonWrite_o && !AvalonWaitReq_i) begin
                chk($sformatf("rand addr%0d", acc), AvalonAddr_o, BASE + 64'(acc));
                chk_data($sformatf("rand data%0d", acc), 32'hF0 + 32'(acc), 1'b1);
                acc++;
            end
            if (Done_o) done_seen = 1'b1;
        end
        chk("rand done seen", {63'd0, done_seen}, 1);
        chk("rand accepted", 64'(acc), 3);
        chk("rand err", Err_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
